// File: rtl/pixel_pair_writer.sv
// Packs a valid/ready pixel stream into even/odd pairs and writes each pair to a
// dual-port frame RAM in one cycle over the pair-index window [START_IDX, END_IDX).
module pixel_pair_writer #(
    parameter int DATA_W    = 8,
    parameter int START_IDX = 2688,
    parameter int END_IDX   = 2816,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] wdata_a,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] wdata_b,
    output logic              busy,
    output logic              done
);

    localparam int                IDX_W   = ADDR_W - 1;
    localparam logic [IDX_W-1:0]  START_V = IDX_W'(START_IDX);
    localparam logic [IDX_W-1:0]  LAST_V  = IDX_W'(END_IDX - 1);

    // state   | meaning
    // S_IDLE  | waiting for start, no handshake
    // S_FIRST | accepting the even pixel
    // S_SECOND| accepting the odd pixel
    // S_WRITE | both RAM ports write the pair at idx
    // S_DONE  | one-cycle done pulse, then back to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   even_q, even_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [DATA_W-1:0]   wdata_a_q, wdata_a_d;
    logic [DATA_W-1:0]   wdata_b_q, wdata_b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs;

    assign hs = in_valid & in_ready_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        even_d    = even_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        wdata_a_d = wdata_a_q;
        wdata_b_d = wdata_b_q;
        we_d      = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = START_V;
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                if (hs) begin
                    even_d  = in_data;
                    state_d = S_SECOND;
                end
            end
            S_SECOND: begin
                // The odd pixel goes straight into the port-B data register, so
                // the write is fully registered by the time WRITE is entered.
                if (hs) begin
                    state_d   = S_WRITE;
                    we_d      = 1'b1;
                    addr_a_d  = {idx_q, 1'b0};
                    addr_b_d  = {idx_q, 1'b1};
                    wdata_a_d = even_q;
                    wdata_b_d = in_data;
                end
            end
            S_WRITE: begin
                if (idx_q == LAST_V) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FIRST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_FIRST) || (state_d == S_SECOND);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= START_V;
            even_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            wdata_a_q  <= '0;
            wdata_b_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            even_q     <= even_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            wdata_a_q  <= wdata_a_d;
            wdata_b_q  <= wdata_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign we_a     = we_q;
    assign we_b     = we_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign wdata_a  = wdata_a_q;
    assign wdata_b  = wdata_b_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/pixel_pair_writer.md
# pixel_pair_writer

Packs a serial pixel stream into pixel pairs and writes each pair to a dual-port frame RAM in one cycle: the even address on port A and the odd address on port B. It is the write-side counterpart of the draw path's paired address counter, and fills the same pair-index window (default indices 2688..2815, i.e. byte addresses 5376..5631). It sits between the pixel source, which uses a valid/ready handshake, and the RAM write ports.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- START_IDX, 2688, first pair index written
- END_IDX, 2816, exclusive end pair index; START_IDX < END_IDX ≤ 8192 required
- ADDR_W, 14, RAM address width; pair index is ADDR_W-1 bits

Ports:
- clk  input  1  single clock, all logic on posedge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a fill; sampled only in IDLE
- in_data  input  DATA_W  pixel from source
- in_valid  input  1  in_data valid
- in_ready  output  1  writer accepts in_data this cycle
- we_a  output  1  port A write enable
- addr_a  output  ADDR_W  port A address = {idx, 1'b0}
- wdata_a  output  DATA_W  even pixel
- we_b  output  1  port B write enable
- addr_b  output  ADDR_W  port B address = {idx, 1'b1}
- wdata_b  output  DATA_W  odd pixel
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last pair is written

## Operation
- FSM states: IDLE, FIRST, SECOND, WRITE, DONE.
- IDLE: in_ready=0. If start=1, load idx=START_IDX and go to FIRST.
- FIRST: in_ready=1. On a handshake (in_valid & in_ready), capture in_data into the even register and go to SECOND. Otherwise stay.
- SECOND: in_ready=1. On a handshake, capture in_data into the odd register and go to WRITE.
- WRITE: in_ready=0.
  - we_a=we_b=1 for exactly this cycle, with addr_a={idx,0}, addr_b={idx,1}, wdata_a=even, wdata_b=odd.
  - If idx==END_IDX-1, go to DONE. Otherwise idx<=idx+1 and go to FIRST.
- DONE: done=1, in_ready=0. Go to IDLE next cycle.
- Pixel order: the first accepted pixel goes to the even address, the second to the odd address.
- idx never exceeds END_IDX-1 and never wraps.
- start outside IDLE is ignored, including in DONE.
- in_valid is ignored whenever in_ready=0; no data is consumed in those cycles.
- Outside WRITE: we_a=we_b=0. addr and wdata hold their last values; they are don't-care for the RAM.

## Timing
- Reset (asynchronous assert, any state) forces:
  - state=IDLE, idx=START_IDX, even/odd registers=0
  - in_ready=0, we_a=we_b=0, addr_a=addr_b=0, wdata_a=wdata_b=0, busy=0, done=0
- Reset mid-fill aborts the fill. A pair captured but not yet in WRITE is discarded; no write is issued.
- Latency from start: start is sampled high at edge 0, and the FSM is in FIRST during cycle 1.
- With in_valid held high, pair k (k from 0) goes through:
  - FIRST in cycle 1+3k
  - SECOND in cycle 2+3k
  - WRITE in cycle 3+3k
- Default window (128 pairs): last WRITE in cycle 384, done in cycle 385, IDLE (busy=0) in cycle 386.
- Throughput is one pair per 3 cycles at best. Each stalled cycle (in_valid=0 in FIRST or SECOND) adds exactly one cycle.
- in_ready is a registered-state decode: it depends only on the current state, never combinationally on in_valid.

## Test plan
- Reset values: assert reset mid-cycle with start=1.
  - Required: all outputs 0 immediately, held while reset=0.
  - After release: busy=0 until start.
- Full default fill: pulse start, hold in_valid=1, in_data=0,1,2,…,255.
  - Required: 128 writes. First write is addr_a=5376/wdata_a=0 and addr_b=5377/wdata_b=1; last is addr_a=5630/254 and addr_b=5631/255.
  - Required: done pulse in cycle 385 only, busy=0 from cycle 386.
- Stalls: drop in_valid for 2 cycles in FIRST and 3 cycles in SECOND on the first pair.
  - Required: the first write moves from cycle 3 to cycle 8 with unchanged data.
  - Required: no we_a/we_b pulse during the stall.
- Ignored inputs: assert start in FIRST, WRITE and DONE, and in_valid in IDLE and WRITE.
  - Required: idx is not reloaded, no extra pixels are consumed, and the write count stays 128.
- Abort: assert reset in SECOND of pair 10 (idx=2698), then release and start again.
  - Required: no write at addr 5396/5397 before reset.
  - Required: the new fill restarts at addr 5376/5377 with fresh data.
- Small window: START_IDX=0, END_IDX=2, stream A,B,C,D.
  - Required: writes (0:A, 1:B) then (2:C, 3:D), done in cycle 7, no write beyond address 3.
